sample_acquisition_seq: RTL and testbench
=========================================

Name: sample_acquisition_seq

Overview:
Parametrised successor to the fixed two-phase (lo/hi) autozero sample-acquisition sequencer. It runs a programmable table of up to DEPTH sequence entries. Each entry sets the azmux and pc-switch values, holds them for a per-entry precharge/settle count, triggers the ADC and waits for its valid handshake. The block sits between register_set (which supplies config and table writes) and the mode/AF output mux in top (which consumes azmux/pc/trig/monitor outputs), replacing the hard-wired lo/hi variant for new acquisition modes.

Parameters:
DEPTH, 8, number of sequence-table entries (power of 2, 2..16)
AZMUX_W, 4, azmux output width
PC_W, 2, pc-switch output width
CNT_W, 24, precharge counter width
AZMUX_PARK, 4'b0000, azmux value driven when idle/disarmed
PC_PARK, 2'b00, pc-switch value driven when idle/disarmed

Ports:
clk  in  1  system clock (CLK in top)
reset  in  1  asynchronous active-high reset
arm_trigger_i  in  1  level; 1 = run sequence continuously, 0 = stop
adc_measure_valid_i  in  1  one-cycle pulse from ADC, measurement complete
p_seq_len_i  in  $clog2(DEPTH)+1  active entries; 0 is treated as 1, values >DEPTH are clamped to DEPTH
tbl_wr_en_i  in  1  table write strobe (already synchronised to clk)
tbl_wr_addr_i  in  $clog2(DEPTH)  table entry index
tbl_wr_data_i  in  AZMUX_W+PC_W+CNT_W  {precharge_count, pc_val, azmux_val}
azmux_o  out  AZMUX_W  az mux drive
sw_pc_ctl_o  out  PC_W  precharge switch drive
adc_measure_trig_o  out  1  one-cycle ADC start pulse
status_o  out  3  FSM state code
seq_idx_o  out  $clog2(DEPTH)  current entry index
sample_count_o  out  32  accepted-valid count, wraps at 2^32
led0_o  out  1  toggles at each completed pass (idx wraps to 0)
monitor_o  out  4  {adc_measure_trig_o, adc_measure_valid_i, state[1:0]}

Behaviour:
- Reset (async assert, release sync to clk): state IDLE; azmux_o=AZMUX_PARK; sw_pc_ctl_o=PC_PARK; trig=0; idx=0; sample_count=0; led0=0. Table contents are not reset (reads undefined until written).
- Table: DEPTH x entry registers. A write takes effect the cycle after tbl_wr_en_i. The entry is latched into working registers on entry to PRECHARGE, so a write to the active entry affects only the next visit.
- States and status_o codes: IDLE=0, PRECHARGE=1, TRIG=2, WAIT=3, NEXT=4.
- IDLE: outputs parked. arm=1 -> PRECHARGE with idx=0, latch entry 0.
- PRECHARGE: azmux_o/sw_pc_ctl_o = latched entry values, registered, driven the first cycle in the state. The counter loads precharge_count and decrements; exit to TRIG when counter==0. Duration = max(count,1) cycles.
- TRIG: adc_measure_trig_o=1 for exactly this one cycle -> WAIT.
- WAIT: hold mux values. On adc_measure_valid_i: sample_count++ -> NEXT. No timeout.
- NEXT (1 cycle): idx = (idx+1==eff_len) ? 0 : idx+1. On wrap, led0 toggles. Latch the new entry -> PRECHARGE.
- Valid pulses outside WAIT are ignored and not counted. A valid in the same cycle as the TRIG pulse is ignored.
- arm=0 in any non-IDLE state: next cycle -> IDLE, outputs parked, trig forced 0, idx reset to 0. The in-flight measurement is abandoned and sample_count is unchanged.
- p_seq_len_i is sampled at each NEXT. If the length shrinks below idx+1, the sequence wraps to 0 at that NEXT.
- Loop overhead: 2 cycles (TRIG, NEXT) + precharge + ADC latency.

Decomposition:
- Shared package sa_seq_pkg holds the state encodings (status codes), entry field offsets, and the default park values, so top and register_set agree on them.
- One natural sub-module, sa_seq_table: a DEPTH-entry register file with a synchronous write port and a combinational read at idx.

Test Plan:
- Reset mid-WAIT (reset=1 for 3 cycles) -> azmux_o=0, sw_pc=0, status=0, sample_count=0 asynchronously, with no trig pulse after release.
- Table {0:(az=3,pc=1,cnt=10), 1:(az=5,pc=2,cnt=4)}, len=2, arm=1, ADC valid 20 cycles after trig -> azmux sequence 3,5,3,5…; trig pulse 10 cycles after PRECHARGE entry for entry 0 and 4 cycles for entry 1; led0 toggles each pass; sample_count=4 after 2 passes.
- len=0 and len=DEPTH+3 -> behave as len=1 (idx stays 0) and len=DEPTH (idx wraps at DEPTH-1) respectively.
- Entry cnt=0 -> PRECHARGE lasts exactly 1 cycle.
- arm dropped in PRECHARGE of entry 1 -> IDLE next cycle, parked outputs, idx=0; re-arm restarts at entry 0 with the count unchanged.
- Spurious valid pulses during PRECHARGE and TRIG -> not counted, FSM unaffected; sample_count increments by 1 per real WAIT completion only.

Source files
------------

// File: rtl/sa_seq_pkg.sv
// sa_seq_pkg: shared state codes, entry field layout and park defaults for the acquisition sequencer
// Items:
//   state_e              FSM state / status_o code (IDLE=0 PRECHARGE=1 TRIG=2 WAIT=3 NEXT=4)
//   *_DEF                default widths and park values, shared with register_set
//   AZ_LSB/pc_lsb/cnt_lsb table entry layout {precharge_count, pc_val, azmux_val}
//   eff_len              sequence length clamp: 0 -> 1, >depth -> depth
package sa_seq_pkg;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRECHARGE = 3'd1,
    ST_TRIG      = 3'd2,
    ST_WAIT      = 3'd3,
    ST_NEXT      = 3'd4
  } state_e;
  localparam int AZMUX_W_DEF = 4;
  localparam int PC_W_DEF = 2;
  localparam int CNT_W_DEF = 24;
  localparam logic [AZMUX_W_DEF-1:0] AZMUX_PARK_DEF = '0;
  localparam logic [PC_W_DEF-1:0] PC_PARK_DEF = '0;
  localparam int AZ_LSB = 0;
  function automatic int pc_lsb(input int az_w);
    return az_w;
  endfunction
  function automatic int cnt_lsb(input int az_w, input int pc_w);
    return az_w + pc_w;
  endfunction
  function automatic int eff_len(input int len, input int depth);
    return len == 0 ? 1 : (len > depth ? depth : len);
  endfunction
endpackage

// File: rtl/sample_acquisition_seq_if.sv
// sample_acquisition_seq_if: table-write bus and ADC handshake between register_set/ADC and the sequencer
// Signals (suffixes are from the sequencer's point of view):
//   tbl_wr_en_i / tbl_wr_addr_i / tbl_wr_data_i  table write port
//   adc_measure_valid_i                          ADC measurement-complete pulse
//   adc_measure_trig_o                           one-cycle ADC start pulse
// Modports: master = register_set/ADC side, slave = sequencer
interface sample_acquisition_seq_if #(
  parameter int DEPTH = 8,
  parameter int AZMUX_W = 4,
  parameter int PC_W = 2,
  parameter int CNT_W = 24
);
  logic                            tbl_wr_en_i;
  logic [$clog2(DEPTH)-1:0]        tbl_wr_addr_i;
  logic [AZMUX_W+PC_W+CNT_W-1:0]   tbl_wr_data_i;
  logic                            adc_measure_valid_i;
  logic                            adc_measure_trig_o;
  modport master (
    output tbl_wr_en_i, tbl_wr_addr_i, tbl_wr_data_i, adc_measure_valid_i,
    input  adc_measure_trig_o
  );
  modport slave (
    input  tbl_wr_en_i, tbl_wr_addr_i, tbl_wr_data_i, adc_measure_valid_i,
    output adc_measure_trig_o
  );
endinterface

// File: rtl/sa_seq_table.sv
// sa_seq_table: DEPTH-entry sequence table, synchronous write, combinational read
// Ports:
//   clk        clock
//   wr_en_i    write strobe; entry updated at the clock edge
//   wr_addr_i  write index
//   wr_data_i  entry {precharge_count, pc_val, azmux_val}
//   rd_addr_i  read index
//   rd_data_o  entry at rd_addr_i
module sa_seq_table #(
  parameter int DEPTH = 8,
  parameter int W = 30
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [W-1:0]             wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [W-1:0]             rd_data_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/sample_acquisition_seq.sv
// sample_acquisition_seq: programmable autozero sample-acquisition sequencer
// Ports:
//   clk, reset            clock; async-assert / sync-release active-high reset
//   bus (slave)           table write port and ADC trig/valid handshake
//   arm_trigger_i         1 = run sequence continuously, 0 = stop and park
//   p_seq_len_i           active entries (0 -> 1, >DEPTH -> DEPTH), sampled in NEXT
//   azmux_o, sw_pc_ctl_o  mux / precharge-switch drive (park values when idle)
//   status_o, seq_idx_o   FSM state code, current entry index
//   sample_count_o        accepted ADC valid count
//   led0_o                toggles on every completed pass
//   monitor_o             {trig, valid, state[1:0]}
module sample_acquisition_seq
  import sa_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AZMUX_W = AZMUX_W_DEF,
  parameter int PC_W = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [AZMUX_W-1:0] AZMUX_PARK = AZMUX_PARK_DEF,
  parameter logic [PC_W-1:0] PC_PARK = PC_PARK_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  sample_acquisition_seq_if.slave  bus,
  input  logic                     arm_trigger_i,
  input  logic [$clog2(DEPTH):0]   p_seq_len_i,
  output logic [AZMUX_W-1:0]       azmux_o,
  output logic [PC_W-1:0]          sw_pc_ctl_o,
  output logic [2:0]               status_o,
  output logic [$clog2(DEPTH)-1:0] seq_idx_o,
  output logic [31:0]              sample_count_o,
  output logic                     led0_o,
  output logic [3:0]               monitor_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = AZMUX_W + PC_W + CNT_W;
  localparam int PC_LSB = pc_lsb(AZMUX_W);
  localparam int CNT_LSB = cnt_lsb(AZMUX_W, PC_W);
  logic [1:0]         rst_sync_q;
  logic               rst_int;
  state_e             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AZMUX_W-1:0] az_q, az_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [31:0]        count_q, count_d;
  logic               led_q, led_d;
  logic [EW-1:0]      entry;
  logic [AW-1:0]      rd_addr;
  logic [LW-1:0]      len_eff;
  logic [LW-1:0]      idx_inc;
  logic               wrap;
  logic               load;
  // Reset asserts immediately but releases two clocks after reset falls,
  // so every flop leaves reset on the same clean edge.
  always_ff @(posedge clk or posedge reset)
    if (reset) rst_sync_q <= 2'b11;
    else rst_sync_q <= {rst_sync_q[0], 1'b0};
  assign rst_int = rst_sync_q[1];
  assign len_eff = LW'(eff_len(int'(p_seq_len_i), DEPTH));
  assign idx_inc = {1'b0, idx_q} + LW'(1);
  // '>=' also catches a length that shrank below the current index.
  assign wrap = idx_inc >= len_eff;
  // Entry to latch on PRECHARGE entry: next index from NEXT, entry 0 from IDLE.
  assign rd_addr = (state_q == ST_NEXT && !wrap) ? idx_inc[AW-1:0] : '0;
  sa_seq_table #(.DEPTH(DEPTH), .W(EW)) u_table (
    .clk       (clk),
    .wr_en_i   (bus.tbl_wr_en_i),
    .wr_addr_i (bus.tbl_wr_addr_i),
    .wr_data_i (bus.tbl_wr_data_i),
    .rd_addr_i (rd_addr),
    .rd_data_o (entry)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    az_d = az_q;
    pc_d = pc_q;
    count_d = count_q;
    led_d = led_q;
    load = 1'b0;
    if (!arm_trigger_i) begin
      state_d = ST_IDLE;
      idx_d = '0;
      az_d = AZMUX_PARK;
      pc_d = PC_PARK;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_PRECHARGE;
          load = 1'b1;
        end
        ST_PRECHARGE: begin
          // Loaded with the count on entry; a count of 0 or 1 gives one cycle.
          cnt_d = cnt_q - CNT_W'(1);
          state_d = cnt_q <= CNT_W'(1) ? ST_TRIG : ST_PRECHARGE;
        end
        ST_TRIG: state_d = ST_WAIT;
        ST_WAIT: begin
          state_d = bus.adc_measure_valid_i ? ST_NEXT : ST_WAIT;
          count_d = count_q + 32'(bus.adc_measure_valid_i);
        end
        ST_NEXT: begin
          state_d = ST_PRECHARGE;
          led_d = led_q ^ wrap;
          load = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
      if (load) begin
        idx_d = rd_addr;
        az_d = entry[AZ_LSB +: AZMUX_W];
        pc_d = entry[PC_LSB +: PC_W];
        cnt_d = entry[CNT_LSB +: CNT_W];
      end
    end
  end
  always_ff @(posedge clk or posedge rst_int)
    if (rst_int) begin
      state_q <= ST_IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      az_q <= AZMUX_PARK;
      pc_q <= PC_PARK;
      count_q <= '0;
      led_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      az_q <= az_d;
      pc_q <= pc_d;
      count_q <= count_d;
      led_q <= led_d;
    end
  assign bus.adc_measure_trig_o = state_q == ST_TRIG;
  assign azmux_o = az_q;
  assign sw_pc_ctl_o = pc_q;
  assign status_o = state_q;
  assign seq_idx_o = idx_q;
  assign sample_count_o = count_q;
  assign led0_o = led_q;
  assign monitor_o = {bus.adc_measure_trig_o, bus.adc_measure_valid_i, state_q[1:0]};
endmodule

// File: tb/tb_sample_acquisition_seq.sv
// tb_sample_acquisition_seq: directed self-checking bench for sample_acquisition_seq
module tb_sample_acquisition_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic arm = 1'b0;
  logic [3:0] len = 4'd2;
  logic adc_v = 1'b0;
  logic spur_v = 1'b0;
  int adc_lat = 20;
  logic [3:0] az;
  logic [1:0] pc;
  logic [2:0] status;
  logic [2:0] idx;
  logic [31:0] cnt;
  logic led;
  logic [3:0] mon;
  logic trig;
  int n_chk = 0;
  int n_fail = 0;
  sample_acquisition_seq_if #(.DEPTH(8), .AZMUX_W(4), .PC_W(2), .CNT_W(24)) bus ();
  assign bus.adc_measure_valid_i = adc_v | spur_v;
  assign trig = bus.adc_measure_trig_o;
  sample_acquisition_seq #(.DEPTH(8), .AZMUX_W(4), .PC_W(2), .CNT_W(24)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .arm_trigger_i  (arm),
    .p_seq_len_i    (len),
    .azmux_o        (az),
    .sw_pc_ctl_o    (pc),
    .status_o       (status),
    .seq_idx_o      (idx),
    .sample_count_o (cnt),
    .led0_o         (led),
    .monitor_o      (mon)
  );
  always #5 clk = ~clk;
  // ADC model: valid pulse adc_lat cycles after each trig pulse.
  initial forever begin
    @(negedge clk);
    if (trig === 1'b1) begin
      repeat (adc_lat - 1) @(negedge clk);
      adc_v = 1'b1;
      @(negedge clk);
      adc_v = 1'b0;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wr(input int a, input int z, input int p, input int c);
    bus.tbl_wr_en_i = 1'b1;
    bus.tbl_wr_addr_i = 3'(a);
    bus.tbl_wr_data_i = {24'(c), 2'(p), 4'(z)};
    @(negedge clk);
    bus.tbl_wr_en_i = 1'b0;
  endtask
  task automatic wait_st(input logic [2:0] st, input int budget, input string tag);
    int n = 0;
    while (status != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (status != st) check(tag, status, st);
  endtask
  // Follows one entry from PRECHARGE to the cycle after NEXT.
  task automatic run_entry(input int ez, input int ep, input int ec, input string tag);
    int n = 0;
    wait_st(3'd1, 200, {tag, "_to_pre"});
    check({tag, "_az"}, az, ez);
    check({tag, "_pc"}, pc, ep);
    while (status == 3'd1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_plen"}, n, ec == 0 ? 1 : ec);
    check({tag, "_mon"}, mon, 4'b1010);
    wait_st(3'd4, 200, {tag, "_to_next"});
    @(negedge clk);
  endtask
  initial begin
    int c0;
    int trigs;
    bus.tbl_wr_en_i = 1'b0;
    bus.tbl_wr_addr_i = '0;
    bus.tbl_wr_data_i = '0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_status", status, 0);
    check("rst_az", az, 0);
    check("rst_pc", pc, 0);
    check("rst_trig", trig, 0);
    check("rst_idx", idx, 0);
    check("rst_cnt", cnt, 0);
    check("rst_led", led, 0);
    check("rst_mon", mon, 0);
    // two-entry sequence, two passes
    wr(0, 3, 1, 10);
    wr(1, 5, 2, 4);
    len = 4'd2;
    arm = 1'b1;
    run_entry(3, 1, 10, "p1e0");
    check("p1e0_idx", idx, 1);
    check("p1e0_led", led, 0);
    check("p1e0_cnt", cnt, 1);
    run_entry(5, 2, 4, "p1e1");
    check("p1e1_idx", idx, 0);
    check("p1e1_led", led, 1);
    check("p1e1_cnt", cnt, 2);
    run_entry(3, 1, 10, "p2e0");
    run_entry(5, 2, 4, "p2e1");
    check("p2_led", led, 0);
    check("p2_cnt", cnt, 4);
    // reset while waiting for the ADC
    wait_st(3'd3, 100, "rw_to_wait");
    reset = 1'b1;
    arm = 1'b0;
    #1;
    check("rw_az", az, 0);
    check("rw_pc", pc, 0);
    check("rw_status", status, 0);
    check("rw_cnt", cnt, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    trigs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      trigs += int'(trig);
    end
    check("rw_no_trig", trigs, 0);
    check("rw_idle", status, 0);
    check("rw_cnt_idle", cnt, 0);
    // len=0 behaves as len=1, cnt=0 gives a one-cycle precharge
    wr(0, 7, 3, 0);
    adc_lat = 3;
    len = 4'd0;
    arm = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_entry(7, 3, 0, "l0");
      check("l0_idx", idx, 0);
      check("l0_led", led, (k + 1) % 2);
    end
    check("l0_cnt", cnt, 3);
    arm = 1'b0;
    repeat (2) @(negedge clk);
    // len above DEPTH clamps to DEPTH
    for (int i = 0; i < 8; i++) wr(i, 15 - i, i % 4, i);
    len = 4'd11;
    arm = 1'b1;
    for (int k = 0; k < 9; k++) begin
      run_entry(15 - (k % 8), (k % 8) % 4, k % 8, "lmax");
      check("lmax_idx", idx, (k + 1) % 8);
    end
    check("lmax_led", led, 0);
    check("lmax_cnt", cnt, 12);
    arm = 1'b0;
    repeat (2) @(negedge clk);
    // arm dropped in PRECHARGE of entry 1
    wr(0, 3, 1, 10);
    wr(1, 5, 2, 4);
    len = 4'd2;
    adc_lat = 5;
    c0 = int'(cnt);
    arm = 1'b1;
    run_entry(3, 1, 10, "ad_e0");
    check("ad_pre1_st", status, 1);
    check("ad_pre1_az", az, 5);
    arm = 1'b0;
    @(negedge clk);
    check("ad_status", status, 0);
    check("ad_az", az, 0);
    check("ad_pc", pc, 0);
    check("ad_idx", idx, 0);
    check("ad_trig", trig, 0);
    check("ad_cnt", cnt, c0 + 1);
    arm = 1'b1;
    run_entry(3, 1, 10, "ad_re");
    check("ad_re_cnt", cnt, c0 + 2);
    check("ad_re_idx", idx, 1);
    arm = 1'b0;
    repeat (2) @(negedge clk);
    // spurious valids in PRECHARGE and in the TRIG cycle
    c0 = int'(cnt);
    arm = 1'b1;
    @(negedge clk);
    spur_v = 1'b1;
    @(negedge clk);
    spur_v = 1'b0;
    check("sp_pre_st", status, 1);
    check("sp_pre_cnt", cnt, c0);
    wait_st(3'd2, 50, "sp_to_trig");
    spur_v = 1'b1;
    @(negedge clk);
    spur_v = 1'b0;
    check("sp_trig_st", status, 3);
    check("sp_trig_cnt", cnt, c0);
    wait_st(3'd4, 50, "sp_to_next");
    check("sp_real_cnt", cnt, c0 + 1);
    arm = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
